// File: rtl/ysyx_22040931_pipe_stage_pkg.sv
// Shared constants for the generic inter-stage pipeline register.
// Covers the NOP encoding, the skid-mode selectors and the skid FSM state encodings.
package ysyx_22040931_pipe_stage_pkg;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   localparam int SKID_OFF = 0;
   localparam int SKID_ON  = 1;

   typedef logic [1:0] skidState_t;

   // State encoding doubles as the occupancy count.
   localparam skidState_t ST_EMPTY = 2'd0;
   localparam skidState_t ST_ONE   = 2'd1;
   localparam skidState_t ST_TWO   = 2'd2;

endpackage

// File: rtl/ysyx_22040931_pipe_skid.sv
// Two-entry skid buffer. The main entry drives the output and the skid entry catches overflow.
// ready_o is registered, which breaks the combinational ready chain between pipeline stages.
module ysyx_22040931_pipe_skid
   import ysyx_22040931_pipe_stage_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush_i,
   input  logic              push_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              pop_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o,
   output logic [1:0]        occupancy_o,
   output logic              ready_o
);

   skidState_t        state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic              ready_q;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         ST_EMPTY: begin
            if (push_i) begin
               main_d  = data_i;
               state_d = ST_ONE;
            end
         end
         ST_ONE: begin
            if (push_i && pop_i) begin
               main_d = data_i;
            end else if (push_i) begin
               skid_d  = data_i;
               state_d = ST_TWO;
            end else if (pop_i) begin
               state_d = ST_EMPTY;
            end
         end
         ST_TWO: begin
            // Upstream sees ready low here, so only a pop can happen.
            if (pop_i) begin
               main_d  = skid_q;
               state_d = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      if (flush_i) begin
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= ST_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         ready_q <= (state_d != ST_TWO);
      end
   end

   assign valid_o     = (state_q != ST_EMPTY);
   assign data_o      = main_q;
   assign occupancy_o = state_q;
   assign ready_o     = ready_q;

endmodule

// File: rtl/ysyx_22040931_pipe_stage.sv
// Generic pipeline register between core stages: valid/ready handshake with flush, stall and bubble
// injection, an optional two-entry skid buffer, and a saturating back-pressure counter.
module ysyx_22040931_pipe_stage
   import ysyx_22040931_pipe_stage_pkg::*;
#(
   parameter int              DATA_W    = 64,
   parameter int              SKID      = SKID_OFF,
   parameter logic [DATA_W-1:0] NOP_VAL = '0,
   parameter bit              NOP_VALID = 1'b1,
   parameter int              CNT_W     = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush_i,
   input  logic              stall_i,
   input  logic              nop_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic [1:0]        occupancy_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   logic              coreReady;
   logic              coreValid;
   logic [DATA_W-1:0] coreData;
   logic [1:0]        coreOcc;
   logic              inFire;
   logic              outFire;
   logic              push;
   logic [DATA_W-1:0] pushData;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   // Stall masks both handshakes, so no fire can occur and the storage simply holds.
   assign in_ready_o  = reset & ~stall_i & coreReady;
   assign out_valid_o = ~stall_i & coreValid;
   assign out_data_o  = coreData;
   assign occupancy_o = coreOcc;

   assign inFire   = in_valid_i & in_ready_o;
   assign outFire  = out_valid_o & out_ready_i;
   assign push     = inFire & (~nop_i | NOP_VALID);
   assign pushData = nop_i ? NOP_VAL : in_data_i;

   generate
      if (SKID == SKID_ON) begin : g_skid
         ysyx_22040931_pipe_skid #(
            .DATA_W (DATA_W)
         ) u_skid (
            .clock       (clock),
            .reset       (reset),
            .flush_i     (flush_i),
            .push_i      (push),
            .data_i      (pushData),
            .pop_i       (outFire),
            .valid_o     (coreValid),
            .data_o      (coreData),
            .occupancy_o (coreOcc),
            .ready_o     (coreReady)
         );
      end else begin : g_single
         logic              valid_q, valid_d;
         logic [DATA_W-1:0] data_q, data_d;

         always_comb begin
            valid_d = valid_q;
            data_d  = data_q;
            if (flush_i) begin
               valid_d = 1'b0;
            end else if (push) begin
               valid_d = 1'b1;
               data_d  = pushData;
            end else if (outFire) begin
               valid_d = 1'b0;
            end
         end

         always_ff @(posedge clock) begin
            if (!reset) begin
               valid_q <= 1'b0;
               data_q  <= '0;
            end else begin
               valid_q <= valid_d;
               data_q  <= data_d;
            end
         end

         assign coreReady = ~valid_q | out_ready_i;
         assign coreValid = valid_q;
         assign coreData  = data_q;
         assign coreOcc   = {1'b0, valid_q};
      end
   endgenerate

   // Counter deliberately ignores flush so perf totals survive pipeline redirects.
   always_comb begin
      cnt_d = cnt_q;
      if ((stall_i || (out_valid_o && !out_ready_i)) && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign stall_cnt_o = cnt_q;

endmodule
